// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule: emits round keys 10 down to 0, one per valid/ready handshake.
// Define INV_KEY_PRECOMPUTE_EN to load the cipher key and forward-expand to round 10 first.
module inv_key_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   round,
    output logic         rk_valid,
    output logic         busy,
    output logic         done
);

`ifdef INV_KEY_PRECOMPUTE_EN
    typedef enum logic [1:0] {StIdle, StPre, StEmit} state_t;
`else
    typedef enum logic [1:0] {StIdle, StEmit} state_t;
`endif

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
    endfunction

    function automatic logic [31:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return {c, 24'h0};
    endfunction

    state_t      state;
    logic [31:0] k0, k1, k2, k3;
    logic [31:0] p0, p1, p2, p3;
    logic [127:0] inv_key;

    always_comb begin
        {k0, k1, k2, k3} = rk_out;
        p3 = k3 ^ k2;
        p2 = k2 ^ k1;
        p1 = k1 ^ k0;
        p0 = k0 ^ sub_rot(p3) ^ rcon(round);
        inv_key = {p0, p1, p2, p3};
    end

`ifdef INV_KEY_PRECOMPUTE_EN
    logic [31:0]  f0, f1, f2, f3;
    logic [127:0] fwd_key;

    // During PRE, round counts forward steps already applied; next step uses Rcon(round+1).
    always_comb begin
        f0 = k0 ^ sub_rot(k3) ^ rcon(round + 4'd1);
        f1 = k1 ^ f0;
        f2 = k2 ^ f1;
        f3 = k3 ^ f2;
        fwd_key = {f0, f1, f2, f3};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            rk_out   <= '0;
            round    <= '0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        rk_out <= key_in;
                        busy   <= 1'b1;
`ifdef INV_KEY_PRECOMPUTE_EN
                        state  <= StPre;
                        round  <= 4'd0;
`else
                        state    <= StEmit;
                        round    <= 4'd10;
                        rk_valid <= 1'b1;
`endif
                    end
                end
`ifdef INV_KEY_PRECOMPUTE_EN
                StPre: begin
                    rk_out <= fwd_key;
                    if (round == 4'd9) begin
                        state    <= StEmit;
                        round    <= 4'd10;
                        rk_valid <= 1'b1;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
`endif
                StEmit: begin
                    if (rk_ready) begin
                        if (round == 4'd0) begin
                            state    <= StIdle;
                            rk_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            rk_out <= inv_key;
                            round  <= round - 4'd1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Bench for inv_key_schedule: forward FIPS-197 expansion model (S-box built from GF(2^8)
// inverse + affine map), keys expected in reverse order; honours INV_KEY_PRECOMPUTE_EN.
module tb_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         rk_ready = 1'b0;
    logic [127:0] rk_out;
    logic [3:0]   round;
    logic         rk_valid;
    logic         busy;
    logic         done;

    int total = 0;
    int bad = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rk [11];
    logic [127:0] obs [11];

`ifdef INV_KEY_PRECOMPUTE_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 1;
`endif

    inv_key_schedule dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .round    (round),
        .rk_valid (rk_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $display("FAIL %s observed=timeout expected=event", tag);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic void build_sbox();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] inv = 8'h00;
            for (int j = 1; j < 256; j++)
                if (i != 0 && gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
            sbox[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic void expand(input logic [127:0] ck);
        logic [31:0] w [44];
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = ck[127 - 32*i -: 32];
        for (int j = 4; j < 44; j++) begin
            logic [31:0] t = w[j-1];
            if (j % 4 == 0) begin
                t = {sbox[t[23:16]] ^ rc, sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]};
                rc = gmul(rc, 8'h02);
            end
            w[j] = w[j-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Full sequence from start to done; rand_rdy randomizes rk_ready, poke drives stray starts.
    task automatic run_seq(input logic [127:0] ck, input bit rand_rdy, input bit poke);
        int n = 0;
        int guard = 0;
        int exp_r = 10;
        bit fin = 0;
        bit rdy;
        expand(ck);
        @(negedge clk);
`ifdef INV_KEY_PRECOMPUTE_EN
        key_in = ck;
`else
        key_in = rk[10];
`endif
        start = 1'b1;
        rk_ready = rand_rdy ? 1'($urandom) : 1'b1;
        do begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (!rk_valid) chk("pre_busy", 128'(busy), 128'd1);
            if (rand_rdy) rk_ready = 1'($urandom);
        end while (!rk_valid && n < 40);
        if (!rk_valid) begin
            timeout("first_valid");
            return;
        end
        chk("latency", 128'(n), 128'(LAT));
        while (!fin && guard < 400) begin
            chk("valid", 128'(rk_valid), 128'd1);
            chk("round", 128'(round), 128'(exp_r));
            chk("key", rk_out, rk[exp_r]);
            chk("busy", 128'(busy), 128'd1);
            chk("done_low", 128'(done), 128'd0);
            obs[exp_r] = rk_out;
            rdy = rand_rdy ? 1'($urandom) : 1'b1;
            rk_ready = rdy;
            start = poke && (exp_r == 5 || (exp_r == 0 && rdy));
            if (start) key_in = {$urandom, $urandom, $urandom, $urandom};
            if (rdy) begin
                if (exp_r == 0) fin = 1;
                else exp_r--;
            end
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        if (!fin) begin
            timeout("final_handshake");
            return;
        end
        chk("end_valid", 128'(rk_valid), 128'd0);
        chk("end_done", 128'(done), 128'd1);
        chk("end_busy", 128'(busy), 128'd0);
        chk("end_round", 128'(round), 128'd0);
        chk("end_key", rk_out, rk[0]);
        rk_ready = 1'($urandom);
        @(negedge clk);
        chk("done_pulse", 128'(done), 128'd0);
        chk("idle_busy", 128'(busy), 128'd0);
        chk("idle_valid", 128'(rk_valid), 128'd0);
        chk("idle_key", rk_out, rk[0]);
    endtask

    initial begin
        logic [127:0] ck;
        int g;
        build_sbox();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_key", rk_out, 128'd0);
        chk("rst_round", 128'(round), 128'd0);
        chk("rst_valid", 128'(rk_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        ck = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        run_seq(ck, 0, 0);
        chk("vec_r10", obs[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("vec_r9", obs[9], 128'hac7766f319fadc2128d12941575c006e);
        chk("vec_r1", obs[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("vec_r0", obs[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        run_seq(ck, 1, 0);
        run_seq(ck, 1, 1);

        // Reset dropped between edges while round 6 is presented.
        expand(ck);
        @(negedge clk);
`ifdef INV_KEY_PRECOMPUTE_EN
        key_in = ck;
`else
        key_in = rk[10];
`endif
        start = 1'b1;
        rk_ready = 1'b1;
        g = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            g++;
        end while (!(rk_valid && round == 4'd6) && g < 60);
        if (!(rk_valid && round == 4'd6)) timeout("reach_round6");
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_key", rk_out, 128'd0);
        chk("mid_rst_round", 128'(round), 128'd0);
        chk("mid_rst_valid", 128'(rk_valid), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_done", 128'(done), 128'd0);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_valid", 128'(rk_valid), 128'd0);
        chk("post_rst_busy", 128'(busy), 128'd0);

        for (int i = 0; i < 3; i++) run_seq({$urandom, $urandom, $urandom, $urandom}, 1, i == 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
